// File: rtl/ps2_codes_pkg.sv
// ps2_codes_pkg: PS/2 scan codes, field encodings and FSM states shared by the clock-set sequencer.
// No ports. Exports the key codes, the SEC/MIN/HOR field select values, state_t and mode_code().
package ps2_codes_pkg;

    localparam logic [7:0] K_BRK   = 8'hF0;
    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_TIME  = 8'h6C;
    localparam logic [7:0] K_ALARM = 8'h75;
    localparam logic [7:0] K_UP    = 8'h73;
    localparam logic [7:0] K_DOWN  = 8'h72;
    localparam logic [7:0] K_LEFT  = 8'h6B;
    localparam logic [7:0] K_RIGHT = 8'h74;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_ESC   = 8'h76;

    localparam logic [1:0] SEC = 2'd0;
    localparam logic [1:0] MIN = 2'd1;
    localparam logic [1:0] HOR = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TIME  = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    // The active mode is reported as the scan code that selected it.
    function automatic logic [7:0] mode_code(input state_t s);
        return s == S_TIME ? K_TIME : s == S_ALARM ? K_ALARM : 8'h00;
    endfunction

endpackage

// File: rtl/ajuste_reloj_ctrl_if.sv
// ajuste_reloj_ctrl_if: keyboard-in / counter-control-out bundle of the clock-set sequencer.
// Signals: scan_code[8], rx_done (from PS/2 receiver); estado[8], en[2], Cambio[8], got_data,
// edit_active, blink (to the hour/minute/second counters and display).
// Modports: master = keyboard side / environment, slave = the sequencer.
interface ajuste_reloj_ctrl_if;

    logic [7:0] scan_code;
    logic       rx_done;
    logic [7:0] estado;
    logic [1:0] en;
    logic [7:0] Cambio;
    logic       got_data;
    logic       edit_active;
    logic       blink;

    modport master (
        output scan_code, rx_done,
        input  estado, en, Cambio, got_data, edit_active, blink
    );

    modport slave (
        input  scan_code, rx_done,
        output estado, en, Cambio, got_data, edit_active, blink
    );

endinterface

// File: rtl/blink_div.sv
// blink_div: enable-gated free-running divider; blink toggles each time the counter wraps.
// Ports: clk, rst (sync, active-high), en (run when 1, cleared when 0), blink (square wave out).
module blink_div #(
    parameter int W = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic blink
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else begin
            cnt <= cnt + W'(1);
            if (&cnt) blink <= !blink;
        end
    end

endmodule

// File: rtl/ajuste_reloj_ctrl.sv
// ajuste_reloj_ctrl: PS/2 scan-code sequencer for the time/alarm set mode of the clock.
// Ports: clk, rst (sync, active-high), bus (ajuste_reloj_ctrl_if.slave):
//   in  scan_code/rx_done; out estado (6C time-set, 75 alarm-set, 00 idle), en (0 sec, 1 min, 2 hour),
//   Cambio (last 73/72), got_data (1-cycle strobe for Cambio), edit_active, blink.
module ajuste_reloj_ctrl
    import ps2_codes_pkg::*;
#(
    parameter int TO_W    = 30,
    parameter int TIMEOUT = 1_000_000_000,
    parameter int BLK_W   = 25
) (
    input logic                clk,
    input logic                rst,
    ajuste_reloj_ctrl_if.slave bus
);

    state_t          state, nxt;
    logic            brk, valid, edit, timeout, adj, exit_key;
    logic [1:0]      en_q;
    logic [7:0]      cambio_q;
    logic            got_q, blink_q;
    logic [TO_W-1:0] timer;

    // valid: a byte that survives the break filter (not F0, not E0, not the byte after F0).
    always_comb begin
        edit     = state != S_IDLE;
        valid    = bus.rx_done && !brk && bus.scan_code != K_BRK && bus.scan_code != K_EXT;
        adj      = valid && edit && (bus.scan_code == K_UP || bus.scan_code == K_DOWN);
        exit_key = valid && edit && (bus.scan_code == K_ENTER || bus.scan_code == K_ESC);
        // A key in the expiry cycle wins over the timeout.
        timeout  = edit && !valid && timer == TO_W'(TIMEOUT - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (valid && bus.scan_code == K_TIME)       nxt = S_TIME;
        else if (valid && bus.scan_code == K_ALARM) nxt = S_ALARM;
        else if (exit_key || timeout)               nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk      <= 1'b0;
            en_q     <= SEC;
            cambio_q <= 8'h00;
            got_q    <= 1'b0;
            timer    <= '0;
        end else begin
            // E0 is transparent to the filter; any other byte either arms or consumes brk.
            if (bus.rx_done && bus.scan_code != K_EXT) brk <= !brk && bus.scan_code == K_BRK;
            got_q <= adj;
            if (adj) cambio_q <= bus.scan_code;
            timer <= (!edit || valid || timeout) ? '0 : timer + TO_W'(1);
            if (nxt == S_IDLE)                                  en_q <= SEC;
            else if (!edit)                                     en_q <= HOR;
            else if (valid && bus.scan_code == K_LEFT)          en_q <= en_q == HOR ? SEC : en_q + 2'd1;
            else if (valid && bus.scan_code == K_RIGHT)         en_q <= en_q == SEC ? HOR : en_q - 2'd1;
        end
    end

    blink_div #(.W(BLK_W)) u_blink (
        .clk   (clk),
        .rst   (rst),
        .en    (edit),
        .blink (blink_q)
    );

    // The divider register lags the exit by one edge, so gate it with the live mode.
    always_comb begin
        bus.estado      = mode_code(state);
        bus.edit_active = edit;
        bus.en          = en_q;
        bus.Cambio      = cambio_q;
        bus.got_data    = got_q;
        bus.blink       = blink_q && edit;
    end

endmodule

// File: tb/tb_ajuste_reloj_ctrl.sv
// tb_ajuste_reloj_ctrl: directed + randomized bench for ajuste_reloj_ctrl with a behavioural model.
// No ports.
module tb_ajuste_reloj_ctrl;

    localparam int TO_W    = 8;
    localparam int TIMEOUT = 20;
    localparam int BLK_W   = 3;

    typedef struct packed {
        logic [7:0] mode;
        int         en;
        logic [7:0] cambio;
        logic       got;
        int         quiet;
        logic       brk;
        int         n;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;
    mdl_t m = '0;
    logic [7:0] codes [12] = '{8'hF0, 8'hE0, 8'h6C, 8'h75, 8'h73, 8'h72,
                               8'h6B, 8'h74, 8'h5A, 8'h76, 8'h11, 8'h1C};

    ajuste_reloj_ctrl_if bus ();

    ajuste_reloj_ctrl #(.TO_W(TO_W), .TIMEOUT(TIMEOUT), .BLK_W(BLK_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One clock of the keyboard-driven mode machine, in terms of modes, fields and quiet cycles.
    function automatic mdl_t step(input mdl_t s, input logic r, input logic v, input logic [7:0] c);
        mdl_t o;
        bit ed, acc;
        o = s;
        ed = s.mode != 8'h00;
        acc = 1'b0;
        if (r) return '0;
        o.got = 1'b0;
        o.n = ed ? s.n + 1 : 0;
        if (v && c != 8'hE0) begin
            if (s.brk) o.brk = 1'b0;
            else if (c == 8'hF0) o.brk = 1'b1;
            else acc = 1'b1;
        end
        if (acc && (c == 8'h6C || c == 8'h75)) begin
            o.mode = c;
            o.en = ed ? s.en : 2;
            o.quiet = 0;
        end else if (acc && ed) begin
            o.quiet = 0;
            if (c == 8'h73 || c == 8'h72) begin
                o.cambio = c;
                o.got = 1'b1;
            end else if (c == 8'h6B) o.en = (s.en + 1) % 3;
            else if (c == 8'h74) o.en = (s.en + 2) % 3;
            else if (c == 8'h5A || c == 8'h76) begin
                o.mode = 8'h00;
                o.en = 0;
            end
        end else if (ed) begin
            o.quiet = s.quiet + 1;
            if (o.quiet == TIMEOUT) begin
                o.mode = 8'h00;
                o.en = 0;
                o.quiet = 0;
            end
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_done = 1'b1;
        bus.scan_code = b;
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) m <= step(m, rst, bus.rx_done, bus.scan_code);

    always @(negedge clk) begin
        if (chk_en) begin
            chk("estado", 32'(bus.estado), 32'(m.mode));
            chk("en", 32'(bus.en), m.en);
            chk("Cambio", 32'(bus.Cambio), 32'(m.cambio));
            chk("got_data", 32'(bus.got_data), 32'(m.got));
            chk("edit_active", 32'(bus.edit_active), 32'(m.mode != 8'h00));
            chk("blink", 32'(bus.blink), 32'(m.mode != 8'h00 && ((m.n >> BLK_W) & 1) != 0));
        end
    end

    initial begin
        bus.rx_done = 1'b0;
        bus.scan_code = 8'h00;
        rst = 1'b1;
        wait_cyc(2);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_estado", 32'(bus.estado), 32'h00);
        chk("rst_en", 32'(bus.en), 0);
        chk("rst_cambio", 32'(bus.Cambio), 32'h00);
        chk("rst_got", 32'(bus.got_data), 0);
        chk("rst_blink", 32'(bus.blink), 0);

        send(8'h6C);
        chk("t1_estado", 32'(bus.estado), 32'h6C);
        chk("t1_en", 32'(bus.en), 2);
        chk("t1_edit", 32'(bus.edit_active), 1);
        send(8'h73);
        chk("t1_got", 32'(bus.got_data), 1);
        chk("t1_cambio", 32'(bus.Cambio), 32'h73);
        wait_cyc(1);
        chk("t1_got_pulse", 32'(bus.got_data), 0);

        send(8'hF0);
        send(8'h73);
        chk("t2_break_got", 32'(bus.got_data), 0);
        send(8'h72);
        chk("t2_got", 32'(bus.got_data), 1);
        chk("t2_cambio", 32'(bus.Cambio), 32'h72);

        send(8'h6B);
        chk("t3_left0", 32'(bus.en), 0);
        send(8'h6B);
        chk("t3_left1", 32'(bus.en), 1);
        send(8'h6B);
        chk("t3_left2", 32'(bus.en), 2);
        send(8'h6B);
        send(8'h74);
        chk("t3_right_wrap", 32'(bus.en), 2);

        send(8'h5A);
        send(8'h75);
        wait_cyc(19);
        chk("t4_edit_before_to", 32'(bus.edit_active), 1);
        wait_cyc(1);
        chk("t4_timeout_edit", 32'(bus.edit_active), 0);
        chk("t4_timeout_estado", 32'(bus.estado), 32'h00);
        send(8'h75);
        wait_cyc(19);
        send(8'h11);
        chk("t4_key_wins", 32'(bus.edit_active), 1);
        wait_cyc(19);
        chk("t4_restart_edit", 32'(bus.edit_active), 1);
        wait_cyc(1);
        chk("t4_restart_to", 32'(bus.edit_active), 0);

        send(8'h73);
        chk("t5_idle_up", 32'(bus.got_data), 0);
        send(8'h72);
        chk("t5_idle_down", 32'(bus.got_data), 0);
        send(8'h75);
        chk("t5_estado", 32'(bus.estado), 32'h75);
        wait_cyc(7);
        chk("t5_blink_low", 32'(bus.blink), 0);
        wait_cyc(1);
        chk("t5_blink_high", 32'(bus.blink), 1);
        send(8'h5A);
        chk("t5_exit_estado", 32'(bus.estado), 32'h00);
        chk("t5_exit_en", 32'(bus.en), 0);
        chk("t5_exit_blink", 32'(bus.blink), 0);

        send(8'h6C);
        rst = 1'b1;
        bus.rx_done = 1'b1;
        bus.scan_code = 8'h73;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rx_done = 1'b0;
        chk("t6_got", 32'(bus.got_data), 0);
        chk("t6_estado", 32'(bus.estado), 32'h00);
        chk("t6_en", 32'(bus.en), 0);
        chk("t6_cambio", 32'(bus.Cambio), 32'h00);
        chk("t6_edit", 32'(bus.edit_active), 0);

        for (int i = 0; i < 3000; i++) begin
            rst = 1'b0;
            bus.rx_done = 1'b0;
            if ($urandom_range(0, 39) == 0) wait_cyc(22);
            rst = $urandom_range(0, 299) == 0;
            bus.rx_done = $urandom_range(0, 2) == 0;
            bus.scan_code = codes[$urandom_range(0, 11)];
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.rx_done = 1'b0;
        wait_cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
